mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Control FSM for the 8x8 sequential multiplier. It schedules four 4x4 partial products through the shared 4x4 multiplier, shifter and 16-bit accumulator register.
//  Per partial product it drives the nibble-select mux, the shift amount, and the accumulator's clk_ena/sclr_n.
//  It raises done when the 16-bit product is in the accumulator.
// PARAMETERS
//  DONE_PULSE    0  0: done held high in CALC_DONE until next start; 1: done high for exactly one cycle
//  ERR_RESTART   1  1: start in ERR launches a new multiply; 0: ERR exits only via sclr
// PORTS
//  clk         in   1  system clock, all state changes on rising edge
//  sclr        in   1  synchronous active-high reset, priority over all inputs
//  start       in   1  single-cycle request to begin a multiply (operands must be stable until done)
//  input_sel   out  2  nibble pair: 00 a[3:0]*b[3:0], 01 a[3:0]*b[7:4], 10 a[7:4]*b[3:0], 11 a[7:4]*b[7:4]
//  shift_sel   out  2  partial-product shift: 00 <<0, 01 <<4, 10 <<8, 11 unused (never driven)
//  clk_ena     out  1  accumulator register load enable
//  acc_sclr_n  out  1  accumulator synchronous clear, active-low
//  busy        out  1  high in LSB/MID/MSB
//  done        out  1  product valid in accumulator
//  state_out   out  3  IDLE 000, LSB 001, MID 010, MSB 011, CALC_DONE 100, ERR 101
// BEHAVIOUR
//  - Registers: 3-bit state, 2-bit cnt, 1-bit done_seen. Outputs decode combinationally from state/cnt; acc_sclr_n also uses start and sclr.
//  - Reset (sclr=1 at edge): state=IDLE, cnt=0. While sclr=1: acc_sclr_n=0 and clk_ena=0, so the accumulator clears on the same edge.
//  - IDLE outputs: input_sel=00, shift_sel=00, clk_ena=0, busy=0, done=0.
//  - Accept: start=1 in IDLE, CALC_DONE, or ERR (ERR only when ERR_RESTART=1).
//    acc_sclr_n=0 in that cycle, so the accumulator clears at that edge; next state=LSB, cnt=0.
//  - Outside an accepted start (and outside sclr), acc_sclr_n=1.
//  - LSB (cnt=0): input_sel=00, shift_sel=00, clk_ena=1; next MID, cnt=1.
//  - MID (cnt=1): input_sel=01, shift_sel=01, clk_ena=1; next MID, cnt=2.
//  - MID (cnt=2): input_sel=10, shift_sel=01, clk_ena=1; next MSB, cnt=3.
//  - MSB (cnt=3): input_sel=11, shift_sel=10, clk_ena=1; next CALC_DONE, cnt=0.
//  - CALC_DONE: clk_ena=0, input_sel=00, shift_sel=00.
//    done=1 (DONE_PULSE=0) or done=1 on first cycle only (DONE_PULSE=1, tracked by done_seen).
//    Stays until start.
//  - Latency: start accepted at edge E; accumulator loads at E+1..E+4; done=1 after E+4. Throughput one multiply per 5 cycles.
//  - Error: start=1 in LSB/MID/MSB -> next state ERR, cnt=0. Abandoned product is discarded.
//    ERR outputs: clk_ena=0, done=0, busy=0.
//    Holding start >1 cycle therefore yields ERR.
//  - sclr mid-operation: next state IDLE on that edge; accumulator cleared; no done.
//  - sclr and start together: sclr wins; state=IDLE; start ignored.
//  - Illegal state encodings (110, 111): next state IDLE.
// TESTING
//  1. sclr=1 two cycles, start=0 -> state_out=000, done=0, clk_ena=0, acc_sclr_n=0 while sclr=1.
//  2. Pulse start in IDLE -> per cycle (input_sel,shift_sel,clk_ena): (00,00,1), (01,01,1), (10,01,1), (11,10,1).
//     Then state_out=100, done=1, busy=0.
//  3. Bench datapath model, a=8'hFF b=8'hFF -> accumulator 16'hFE01 when done=1.
//     Also a=8'h12 b=8'h34 -> 16'h03A8; a=8'h00 b=8'hA5 -> 16'h0000.
//  4. Start pulse in MID (cnt=1) -> next state_out=101, clk_ena=0, done=0.
//     Then start -> new multiply from LSB with correct product.
//  5. sclr=1 during MSB -> next cycle state_out=000, accumulator 16'h0000, done never asserted.
//     sclr+start together in IDLE -> stays IDLE.
//  6. Back-to-back: start in CALC_DONE -> LSB next cycle, accumulator cleared.
//     DONE_PULSE=1 build: done high exactly one cycle.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mult_seq_ctrl : control FSM for the 8x8 multiplier built on one 4x4 unit
// Revision 1.0
// ============================================================================
module mult_seq_ctrl #(
  parameter bit DONE_PULSE  = 1'b0,
  parameter bit ERR_RESTART = 1'b1
) (
  input  logic       clk,
  input  logic       sclr,
  input  logic       start,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       clk_ena,
  output logic       acc_sclr_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_out
);

  localparam logic [2:0] S_IDLE      = 3'b000;
  localparam logic [2:0] S_LSB       = 3'b001;
  localparam logic [2:0] S_MID       = 3'b010;
  localparam logic [2:0] S_MSB       = 3'b011;
  localparam logic [2:0] S_CALC_DONE = 3'b100;
  localparam logic [2:0] S_ERR       = 3'b101;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       done_seen;
  logic       accept;
  logic       in_calc;

  assign in_calc = (state == S_LSB) || (state == S_MID) || (state == S_MSB);
  assign accept  = start && ((state == S_IDLE) || (state == S_CALC_DONE) ||
                             ((state == S_ERR) && ERR_RESTART));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_CALC_DONE, S_ERR: begin
        if (accept) begin
          state_nxt = S_LSB;
          cnt_nxt   = 2'd0;
        end
      end
      S_LSB: begin
        state_nxt = S_MID;
        cnt_nxt   = 2'd1;
      end
      S_MID: begin
        // MID covers two partial products: the two cross terms share <<4
        if (cnt == 2'd1) begin
          state_nxt = S_MID;
          cnt_nxt   = 2'd2;
        end else begin
          state_nxt = S_MSB;
          cnt_nxt   = 2'd3;
        end
      end
      S_MSB: begin
        state_nxt = S_CALC_DONE;
        cnt_nxt   = 2'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
    // A new request while a product is in flight abandons it
    if (in_calc && start) begin
      state_nxt = S_ERR;
      cnt_nxt   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      done_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      done_seen <= (state == S_CALC_DONE);
    end
  end

  always_comb begin
    input_sel = 2'b00;
    shift_sel = 2'b00;
    case (state)
      S_LSB: begin
        input_sel = 2'b00;
        shift_sel = 2'b00;
      end
      S_MID: begin
        input_sel = (cnt == 2'd1) ? 2'b01 : 2'b10;
        shift_sel = 2'b01;
      end
      S_MSB: begin
        input_sel = 2'b11;
        shift_sel = 2'b10;
      end
      default: begin
        input_sel = 2'b00;
        shift_sel = 2'b00;
      end
    endcase
  end

  assign clk_ena    = in_calc && !sclr;
  assign acc_sclr_n = !(sclr || accept);
  assign busy       = in_calc;
  assign done       = (state == S_CALC_DONE) && (!DONE_PULSE || !done_seen);
  assign state_out  = state;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mult_seq_ctrl : directed bench with a small accumulator datapath model
// Revision 1.0
// ============================================================================
module tb_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       sclr;
  logic       start;
  logic [1:0] input_sel, shift_sel, input_sel_p, shift_sel_p;
  logic       clk_ena, acc_sclr_n, busy, done;
  logic       clk_ena_p, acc_sclr_n_p, busy_p, done_p;
  logic [2:0] state_out, state_out_p;

  logic [7:0]  a, b;
  logic [15:0] acc;
  logic [3:0]  a_n, b_n;
  logic [7:0]  pp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.DONE_PULSE(1'b0), .ERR_RESTART(1'b1)) dut (
    .clk(clk), .sclr(sclr), .start(start), .input_sel(input_sel),
    .shift_sel(shift_sel), .clk_ena(clk_ena), .acc_sclr_n(acc_sclr_n),
    .busy(busy), .done(done), .state_out(state_out)
  );

  mult_seq_ctrl #(.DONE_PULSE(1'b1), .ERR_RESTART(1'b1)) dut_p (
    .clk(clk), .sclr(sclr), .start(start), .input_sel(input_sel_p),
    .shift_sel(shift_sel_p), .clk_ena(clk_ena_p), .acc_sclr_n(acc_sclr_n_p),
    .busy(busy_p), .done(done_p), .state_out(state_out_p)
  );

  // Shared 4x4 multiplier, shifter and accumulator driven by the controller
  assign a_n = input_sel[1] ? a[7:4] : a[3:0];
  assign b_n = input_sel[0] ? b[7:4] : b[3:0];
  assign pp  = a_n * b_n;

  always @(posedge clk) begin
    if (!acc_sclr_n)
      acc <= 16'h0000;
    else if (clk_ena)
      acc <= acc + ({8'h00, pp} << (4 * shift_sel));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in IDLE/CALC_DONE/ERR, walk the four partial products, check result
  task automatic run_mult(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] prod);
    logic [4:0] exp_tab [4];
    exp_tab[0] = 5'b00_00_1;
    exp_tab[1] = 5'b01_01_1;
    exp_tab[2] = 5'b10_01_1;
    exp_tab[3] = 5'b11_10_1;
    a = ia;
    b = ib;
    start = 1'b1;
    #1;
    chk("accept_acc_sclr_n", acc_sclr_n, 0);
    step();
    start = 1'b0;
    chk("acc_cleared", acc, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sched%0d", i), {input_sel, shift_sel, clk_ena}, exp_tab[i]);
      chk($sformatf("busy%0d", i), busy, 1);
      step();
    end
    chk("done_state", state_out, 3'b100);
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_pulse_first", done_p, 1);
    chk("product", acc, prod);
  endtask

  initial begin
    sclr  = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_state", state_out, 3'b000);
      chk("rst_done", done, 0);
      chk("rst_clk_ena", clk_ena, 0);
      chk("rst_acc_sclr_n", acc_sclr_n, 0);
      chk("rst_busy", busy, 0);
    end
    sclr = 1'b0;
    #1;
    chk("idle_acc_sclr_n", acc_sclr_n, 1);
    chk("idle_sel", {input_sel, shift_sel, clk_ena}, 5'b00000);
    step();

    run_mult(8'hFF, 8'hFF, 16'hFE01);
    step();
    chk("done_level_hold", done, 1);
    chk("done_pulse_one_cycle", done_p, 0);
    chk("calc_done_clk_ena", clk_ena, 0);
    chk("hold_product", acc, 16'hFE01);

    // Back-to-back from CALC_DONE
    run_mult(8'h12, 8'h34, 16'h03A8);
    run_mult(8'h00, 8'hA5, 16'h0000);

    // Start during MID cnt=1 -> ERR
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("in_mid", state_out, 3'b010);
    chk("mid1_sel", input_sel, 2'b01);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_state", state_out, 3'b101);
    chk("err_clk_ena", clk_ena, 0);
    chk("err_done", done, 0);
    chk("err_busy", busy, 0);
    step();
    chk("err_stays", state_out, 3'b101);
    run_mult(8'h12, 8'h34, 16'h03A8);

    // sclr during MSB
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("in_msb", state_out, 3'b011);
    sclr = 1'b1;
    #1;
    chk("sclr_clk_ena", clk_ena, 0);
    chk("sclr_acc_sclr_n", acc_sclr_n, 0);
    step();
    sclr = 1'b0;
    chk("sclr_idle", state_out, 3'b000);
    chk("sclr_acc", acc, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk("no_done_after_sclr", done, 0);
      step();
    end

    // sclr and start together: sclr wins
    sclr  = 1'b1;
    start = 1'b1;
    step();
    chk("sclr_start_idle", state_out, 3'b000);
    sclr  = 1'b0;
    start = 1'b0;
    step();
    chk("still_idle", state_out, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end by 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
